ddr3_lanectrl_dly_seq: RTL and testbench

//  Sequences the lane controller delay-line control pins (SEL/LOAD/DIRECTION/MOVE) and HS_IO_CLK_PAUSE
//  on behalf of the DDR3 PHY training logic. Accepts one tap-move or delay-line-load request at a time

---
 rtl/ddr3_lanectrl_dly_seq.sv | 207 ++++++++++++++++++++
 tb/tb_ddr3_lanectrl_dly_seq.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_lanectrl_dly_seq.sv
// ----------------------------------------------------------------------------
// ddr3_lanectrl_dly_seq
//
// Purpose:
//   Drives the LANECTRL delay-line control pins (SEL/LOAD/DIRECTION/MOVE) and
//   HS_IO_CLK_PAUSE on behalf of the DDR3 PHY training logic. One request is
//   taken at a time over a valid/ready handshake. A move request issues a
//   spaced train of MOVE pulses. It aborts early if the selected delay line
//   reports out-of-range. A load request brackets a single LOAD pulse with
//   HS_IO_CLK_PAUSE. Every request ends with a one-cycle DONE carrying STATUS
//   and TAPS_MOVED.
//
// Ports:
//   FAB_CLK, RESET              fabric clock, asynchronous active-high reset
//   REQ_VALID/REQ_READY         request handshake (READY high only when idle)
//   REQ_OP                      00 move, 01 load, 1x illegal
//   REQ_SEL/REQ_DIR/REQ_TAPS    delay line select, move direction, tap count
//   DONE/STATUS/TAPS_MOVED      completion pulse, 00 ok / 01 oor / 10 illegal,
//                               count of MOVE pulses issued
//   DELAY_LINE_*                control pins to LANECTRL
//   HS_IO_CLK_PAUSE             to LANECTRL pause synchroniser
//   RX/TX_DELAY_LINE_OUT_OF_RANGE  range flags from LANECTRL
// ----------------------------------------------------------------------------
module ddr3_lanectrl_dly_seq #(
  parameter int TAP_W      = 8,
  parameter int MOVE_GAP   = 4,
  parameter int PAUSE_LEAD = 2,
  parameter int PAUSE_LAG  = 2
) (
  input  logic             FAB_CLK,
  input  logic             RESET,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [1:0]       REQ_OP,
  input  logic             REQ_SEL,
  input  logic             REQ_DIR,
  input  logic [TAP_W-1:0] REQ_TAPS,
  output logic             DONE,
  output logic [1:0]       STATUS,
  output logic [TAP_W-1:0] TAPS_MOVED,
  output logic             DELAY_LINE_SEL,
  output logic             DELAY_LINE_DIRECTION,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_LOAD,
  output logic             HS_IO_CLK_PAUSE,
  input  logic             RX_DELAY_LINE_OUT_OF_RANGE,
  input  logic             TX_DELAY_LINE_OUT_OF_RANGE
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_MOVE, S_GAP, S_PAUSE_PRE, S_LOAD, S_PAUSE_POST, S_FIN
  } state_t;

  // A tap occupies one MOVE cycle plus MOVE_GAP-1 GAP cycles. r_cnt is 1 in
  // the first GAP cycle, so the last one is reached at MOVE_GAP-1.
  localparam logic [3:0]       GAP_LAST  = 4'(MOVE_GAP - 1);
  localparam logic [3:0]       LEAD_LAST = 4'(PAUSE_LEAD);
  localparam logic [3:0]       LAG_LAST  = 4'(PAUSE_LAG);
  localparam logic [TAP_W-1:0] ONE_TAP   = TAP_W'(1);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_OOR     = 2'b01;
  localparam logic [1:0] ST_ILLEGAL = 2'b10;

  state_t             r_state, w_state;
  logic [3:0]         r_cnt, w_cnt;
  logic [TAP_W-1:0]   r_moved, w_moved;
  logic [TAP_W-1:0]   r_taps, w_taps;
  logic               r_sel, w_sel;
  logic               r_dir, w_dir;
  logic [1:0]         r_status, w_status;
  logic [TAP_W-1:0]   r_taps_moved, w_taps_moved;
  logic               r_ready, r_done, r_move, r_load, r_pause;
  logic               w_oor;

  // Only the range flag of the delay line being moved may abort the move.
  assign w_oor = r_sel ? TX_DELAY_LINE_OUT_OF_RANGE : RX_DELAY_LINE_OUT_OF_RANGE;

  always_comb begin
    w_state      = r_state;
    w_cnt        = r_cnt;
    w_moved      = r_moved;
    w_taps       = r_taps;
    w_sel        = r_sel;
    w_dir        = r_dir;
    w_status     = r_status;
    w_taps_moved = r_taps_moved;
    unique case (r_state)
      S_IDLE: begin
        if (REQ_VALID) begin
          w_moved = '0;
          if (REQ_OP[1]) begin
            // Illegal op leaves every pin untouched, including SEL/DIR.
            w_state      = S_FIN;
            w_status     = ST_ILLEGAL;
            w_taps_moved = '0;
          end else begin
            w_sel  = REQ_SEL;
            w_dir  = REQ_DIR;
            w_taps = REQ_TAPS;
            if (REQ_OP[0]) begin
              w_state = S_PAUSE_PRE;
              w_cnt   = 4'd1;
            end else if (REQ_TAPS == '0) begin
              w_state      = S_FIN;
              w_status     = ST_OK;
              w_taps_moved = '0;
            end else begin
              w_state = S_SETUP;
            end
          end
        end
      end
      S_SETUP: begin
        w_state = S_MOVE;
        w_moved = r_moved + ONE_TAP;
      end
      S_MOVE: begin
        w_state = S_GAP;
        w_cnt   = 4'd1;
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          if (w_oor) begin
            w_state      = S_FIN;
            w_status     = ST_OOR;
            w_taps_moved = r_moved;
          end else if (r_moved == r_taps) begin
            w_state      = S_FIN;
            w_status     = ST_OK;
            w_taps_moved = r_moved;
          end else begin
            w_state = S_MOVE;
            w_moved = r_moved + ONE_TAP;
          end
        end else begin
          w_cnt = r_cnt + 4'd1;
        end
      end
      S_PAUSE_PRE: begin
        if (r_cnt == LEAD_LAST) w_state = S_LOAD;
        else                    w_cnt   = r_cnt + 4'd1;
      end
      S_LOAD: begin
        w_state = S_PAUSE_POST;
        w_cnt   = 4'd1;
      end
      S_PAUSE_POST: begin
        if (r_cnt == LAG_LAST) begin
          w_state      = S_FIN;
          w_status     = ST_OK;
          w_taps_moved = '0;
        end else begin
          w_cnt = r_cnt + 4'd1;
        end
      end
      S_FIN:   w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  // Pin outputs are registered decodes of the next state, so each pin is
  // aligned with the state it belongs to and comes straight from a flop.
  always_ff @(posedge FAB_CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_moved      <= '0;
      r_taps       <= '0;
      r_sel        <= 1'b0;
      r_dir        <= 1'b0;
      r_status     <= '0;
      r_taps_moved <= '0;
      r_ready      <= 1'b1;
      r_done       <= 1'b0;
      r_move       <= 1'b0;
      r_load       <= 1'b0;
      r_pause      <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_moved      <= w_moved;
      r_taps       <= w_taps;
      r_sel        <= w_sel;
      r_dir        <= w_dir;
      r_status     <= w_status;
      r_taps_moved <= w_taps_moved;
      r_ready      <= (w_state == S_IDLE);
      r_done       <= (w_state == S_FIN);
      r_move       <= (w_state == S_MOVE);
      r_load       <= (w_state == S_LOAD);
      r_pause      <= (w_state == S_PAUSE_PRE) || (w_state == S_LOAD) ||
                      (w_state == S_PAUSE_POST);
    end
  end

  assign REQ_READY            = r_ready;
  assign DONE                 = r_done;
  assign STATUS               = r_status;
  assign TAPS_MOVED           = r_taps_moved;
  assign DELAY_LINE_SEL       = r_sel;
  assign DELAY_LINE_DIRECTION = r_dir;
  assign DELAY_LINE_MOVE      = r_move;
  assign DELAY_LINE_LOAD      = r_load;
  assign HS_IO_CLK_PAUSE      = r_pause;

endmodule

// File: tb/tb_ddr3_lanectrl_dly_seq.sv
// ----------------------------------------------------------------------------
// tb_ddr3_lanectrl_dly_seq
//
// Self-checking bench for ddr3_lanectrl_dly_seq with default parameters
// (TAP_W=8, MOVE_GAP=4, PAUSE_LEAD=2, PAUSE_LAG=2). Each request pushes its
// expected completion (status, taps moved, DONE cycle) onto a queue. A
// monitor pops the queue on every DONE. Scenario tasks capture per-cycle pin
// activity relative to the accept cycle and compare it against expected bit
// patterns.
// ----------------------------------------------------------------------------
module tb_ddr3_lanectrl_dly_seq;

  logic       FAB_CLK = 1'b0;
  logic       RESET;
  logic       REQ_VALID;
  logic       REQ_READY;
  logic [1:0] REQ_OP;
  logic       REQ_SEL;
  logic       REQ_DIR;
  logic [7:0] REQ_TAPS;
  logic       DONE;
  logic [1:0] STATUS;
  logic [7:0] TAPS_MOVED;
  logic       DELAY_LINE_SEL;
  logic       DELAY_LINE_DIRECTION;
  logic       DELAY_LINE_MOVE;
  logic       DELAY_LINE_LOAD;
  logic       HS_IO_CLK_PAUSE;
  logic       RX_OOR;
  logic       TX_OOR;

  ddr3_lanectrl_dly_seq #(
    .TAP_W(8), .MOVE_GAP(4), .PAUSE_LEAD(2), .PAUSE_LAG(2)
  ) dut (
    .FAB_CLK                    (FAB_CLK),
    .RESET                      (RESET),
    .REQ_VALID                  (REQ_VALID),
    .REQ_READY                  (REQ_READY),
    .REQ_OP                     (REQ_OP),
    .REQ_SEL                    (REQ_SEL),
    .REQ_DIR                    (REQ_DIR),
    .REQ_TAPS                   (REQ_TAPS),
    .DONE                       (DONE),
    .STATUS                     (STATUS),
    .TAPS_MOVED                 (TAPS_MOVED),
    .DELAY_LINE_SEL             (DELAY_LINE_SEL),
    .DELAY_LINE_DIRECTION       (DELAY_LINE_DIRECTION),
    .DELAY_LINE_MOVE            (DELAY_LINE_MOVE),
    .DELAY_LINE_LOAD            (DELAY_LINE_LOAD),
    .HS_IO_CLK_PAUSE            (HS_IO_CLK_PAUSE),
    .RX_DELAY_LINE_OUT_OF_RANGE (RX_OOR),
    .TX_DELAY_LINE_OUT_OF_RANGE (TX_OOR)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  typedef struct {
    logic [1:0] st;
    logic [7:0] tm;
    int         at;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  logic [31:0] cap_move, cap_load, cap_pause, cap_done, cap_ready, cap_sel, cap_dir;
  int          cap_nmove;

  always @(posedge FAB_CLK) cyc <= cyc + 1;

  // Scoreboard monitor: every DONE must match the oldest outstanding request.
  always @(posedge FAB_CLK) begin
    #2;
    if (DONE === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL done_unexpected: DONE at cycle %0d status=%b taps=%0d, no request outstanding",
                 cyc, STATUS, TAPS_MOVED);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (STATUS !== e.st || TAPS_MOVED !== e.tm || cyc !== e.at) begin
          bad++;
          $display("FAIL done_result: got status=%b taps=%0d cycle=%0d, want status=%b taps=%0d cycle=%0d",
                   STATUS, TAPS_MOVED, cyc, e.st, e.tm, e.at);
        end
      end
    end
  end

  // Drive one request in the current cycle (cycle 0 of the request) and push
  // its expected completion, lat cycles after accept.
  task automatic start(input logic [1:0] op, input logic sel, input logic dir,
                       input logic [7:0] taps, input logic [1:0] st,
                       input logic [7:0] tm, input int lat);
    exp_t e;
    REQ_OP    = op;
    REQ_SEL   = sel;
    REQ_DIR   = dir;
    REQ_TAPS  = taps;
    REQ_VALID = 1'b1;
    e.st = st; e.tm = tm; e.at = cyc + lat;
    exp_q.push_back(e);
  endtask

  task automatic push_exp(input logic [1:0] st, input logic [7:0] tm, input int at);
    exp_t e;
    e.st = st; e.tm = tm; e.at = at;
    exp_q.push_back(e);
  endtask

  // Step n cycles, recording pins at cycle c (bit c). VALID drops at drop_at.
  // RX out-of-range rises at rx_at.
  task automatic capture(input int n, input int drop_at, input int rx_at);
    cap_move = '0; cap_load = '0; cap_pause = '0; cap_done = '0;
    cap_ready = '0; cap_sel = '0; cap_dir = '0; cap_nmove = 0;
    for (int c = 1; c <= n; c++) begin
      @(posedge FAB_CLK); #1;
      if (c == drop_at) REQ_VALID = 1'b0;
      if (c == rx_at)   RX_OOR = 1'b1;
      if (c < 32) begin
        cap_move[c]  = DELAY_LINE_MOVE;
        cap_load[c]  = DELAY_LINE_LOAD;
        cap_pause[c] = HS_IO_CLK_PAUSE;
        cap_done[c]  = DONE;
        cap_ready[c] = REQ_READY;
        cap_sel[c]   = DELAY_LINE_SEL;
        cap_dir[c]   = DELAY_LINE_DIRECTION;
      end
      if (DELAY_LINE_MOVE === 1'b1) cap_nmove++;
    end
  endtask

  task automatic test_reset();
    logic [16:0] obs;
    repeat (3) @(posedge FAB_CLK);
    #1;
    obs = {REQ_READY, DONE, STATUS, TAPS_MOVED, DELAY_LINE_SEL, DELAY_LINE_DIRECTION,
           DELAY_LINE_MOVE, DELAY_LINE_LOAD, HS_IO_CLK_PAUSE};
    total++;
    if (obs !== 17'h10000) begin
      bad++; $display("FAIL reset_values: got %h want %h", obs, 17'h10000);
    end
    RESET = 1'b0;
    @(posedge FAB_CLK); #1;
    obs = {REQ_READY, DONE, STATUS, TAPS_MOVED, DELAY_LINE_SEL, DELAY_LINE_DIRECTION,
           DELAY_LINE_MOVE, DELAY_LINE_LOAD, HS_IO_CLK_PAUSE};
    total++;
    if (obs !== 17'h10000) begin
      bad++; $display("FAIL after_release: got %h want %h", obs, 17'h10000);
    end
    // Reset in the third GAP cycle of a move: everything clears at once.
    start(2'b00, 1'b1, 1'b1, 8'd5, 2'b00, 8'd5, 22);
    capture(5, 1, -1);
    total++;
    if (DELAY_LINE_SEL !== 1'b1 || cap_move !== 32'h4) begin
      bad++; $display("FAIL pre_reset_move: got sel=%b move=%h want sel=1 move=4",
                      DELAY_LINE_SEL, cap_move);
    end
    RESET = 1'b1;
    #1;
    total++;
    if ({DELAY_LINE_MOVE, DELAY_LINE_SEL, DELAY_LINE_DIRECTION, DONE, REQ_READY} !== 5'b00001) begin
      bad++; $display("FAIL midop_reset: got move/sel/dir/done/ready=%b want 00001",
                      {DELAY_LINE_MOVE, DELAY_LINE_SEL, DELAY_LINE_DIRECTION, DONE, REQ_READY});
    end
    exp_q.delete();
    repeat (2) @(posedge FAB_CLK);
    #1;
    RESET = 1'b0;
    capture(20, -1, -1);
    total++;
    if (cap_done !== 32'h0 || cap_move !== 32'h0 || cap_ready !== 32'h1FFFFE) begin
      bad++; $display("FAIL post_reset_idle: got done=%h move=%h ready=%h want 0 0 1ffffe",
                      cap_done, cap_move, cap_ready);
    end
  endtask

  task automatic test_move();
    start(2'b00, 1'b1, 1'b1, 8'd3, 2'b00, 8'd3, 14);
    capture(16, 1, -1);
    total++;
    if (cap_move !== 32'h444) begin
      bad++; $display("FAIL move_pulses: got %h want %h", cap_move, 32'h444);
    end
    total++;
    if (cap_sel !== 32'h1FFFE || cap_dir !== 32'h1FFFE) begin
      bad++; $display("FAIL move_sel_dir: got sel=%h dir=%h want 1fffe", cap_sel, cap_dir);
    end
    total++;
    if (cap_done !== 32'h4000 || cap_ready !== 32'h18000) begin
      bad++; $display("FAIL move_done_ready: got done=%h ready=%h want 4000 18000",
                      cap_done, cap_ready);
    end
    total++;
    if (cap_pause !== 32'h0 || cap_load !== 32'h0) begin
      bad++; $display("FAIL move_no_pause: got pause=%h load=%h want 0 0", cap_pause, cap_load);
    end
  endtask

  task automatic test_oor_abort();
    start(2'b00, 1'b0, 1'b0, 8'd10, 2'b01, 8'd2, 10);
    capture(12, 1, 8);
    RX_OOR = 1'b0;
    total++;
    if (cap_move !== 32'h44 || cap_done !== 32'h400) begin
      bad++; $display("FAIL oor_abort: got move=%h done=%h want 44 400", cap_move, cap_done);
    end
    total++;
    if (STATUS !== 2'b01 || TAPS_MOVED !== 8'd2) begin
      bad++; $display("FAIL oor_status_hold: got status=%b taps=%0d want 01 2", STATUS, TAPS_MOVED);
    end
    // TX range flag must not abort a move on the RX line.
    TX_OOR = 1'b1;
    start(2'b00, 1'b0, 1'b0, 8'd2, 2'b00, 8'd2, 10);
    capture(12, 1, -1);
    TX_OOR = 1'b0;
    total++;
    if (cap_move !== 32'h44 || cap_done !== 32'h400) begin
      bad++; $display("FAIL oor_other_line: got move=%h done=%h want 44 400", cap_move, cap_done);
    end
  endtask

  task automatic test_load();
    RX_OOR = 1'b1;
    TX_OOR = 1'b1;
    start(2'b01, 1'b0, 1'b0, 8'd7, 2'b00, 8'd0, 6);
    capture(8, 1, -1);
    RX_OOR = 1'b0;
    TX_OOR = 1'b0;
    total++;
    if (cap_pause !== 32'h3E) begin
      bad++; $display("FAIL load_pause: got %h want %h", cap_pause, 32'h3E);
    end
    total++;
    if (cap_load !== 32'h8 || cap_move !== 32'h0 || cap_done !== 32'h40) begin
      bad++; $display("FAIL load_pulse: got load=%h move=%h done=%h want 8 0 40",
                      cap_load, cap_move, cap_done);
    end
  endtask

  task automatic test_zero_illegal();
    start(2'b00, 1'b1, 1'b0, 8'd0, 2'b00, 8'd0, 1);
    capture(4, 1, -1);
    total++;
    if (cap_move !== 32'h0 || cap_done !== 32'h2) begin
      bad++; $display("FAIL zero_taps: got move=%h done=%h want 0 2", cap_move, cap_done);
    end
    start(2'b11, 1'b0, 1'b1, 8'd5, 2'b10, 8'd0, 1);
    capture(4, 1, -1);
    total++;
    if (cap_done !== 32'h2 || cap_sel !== 32'h1E || cap_dir !== 32'h0 ||
        (cap_move | cap_load | cap_pause) !== 32'h0) begin
      bad++; $display("FAIL illegal_op: got done=%h sel=%h dir=%h act=%h want 2 1e 0 0",
                      cap_done, cap_sel, cap_dir, cap_move | cap_load | cap_pause);
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    t0 = cyc;
    start(2'b00, 1'b0, 1'b1, 8'd1, 2'b00, 8'd1, 6);
    push_exp(2'b00, 8'd1, t0 + 13);
    capture(15, 8, -1);
    total++;
    if (cap_move !== 32'h204 || cap_done !== 32'h2040) begin
      bad++; $display("FAIL b2b_timing: got move=%h done=%h want 204 2040", cap_move, cap_done);
    end
    total++;
    if (cap_ready !== 32'hC080) begin
      bad++; $display("FAIL b2b_ready: got %h want %h", cap_ready, 32'hC080);
    end
  endtask

  task automatic test_max_taps();
    start(2'b00, 1'b1, 1'b0, 8'd255, 2'b00, 8'd255, 1022);
    capture(1025, 1, -1);
    total++;
    if (cap_nmove !== 255) begin
      bad++; $display("FAIL max_taps: got %0d pulses want 255", cap_nmove);
    end
  endtask

  initial begin
    RESET     = 1'b1;
    REQ_VALID = 1'b0;
    REQ_OP    = 2'b00;
    REQ_SEL   = 1'b0;
    REQ_DIR   = 1'b0;
    REQ_TAPS  = 8'd0;
    RX_OOR    = 1'b0;
    TX_OOR    = 1'b0;
    test_reset();
    test_move();
    test_oor_abort();
    test_load();
    test_zero_illegal();
    test_back_to_back();
    test_max_taps();
    @(posedge FAB_CLK); #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL missing_done: got %0d requests without DONE want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
